// File: rtl/odd_even_sort_engine.sv
// Odd-even transposition sorter: sorts DATA_NUM values in place, one compare phase per clock,
// tagging each element with its original slot. Optional macro SORT_EARLY_EXIT_EN ends SORT after two swap-free phases.
//
// state | meaning
// IDLE  | waiting for an input vector (in_ready=1)
// SORT  | one odd/even compare phase per cycle (busy=1)
// DONE  | result held on out_* until out_ready
module odd_even_sort_engine #(
    parameter int FIX_POINT_WIDTH = 16,
    parameter int DATA_NUM        = 8,
    parameter int IDX_WIDTH       = 3,
    parameter int SIGNED          = 1
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [DATA_NUM*FIX_POINT_WIDTH-1:0] in_data,
    input  logic                                descending,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [DATA_NUM*FIX_POINT_WIDTH-1:0] out_data,
    output logic [DATA_NUM*IDX_WIDTH-1:0]       out_idx,
    output logic [FIX_POINT_WIDTH-1:0]          max_out,
    output logic                                busy,
    output logic                                sort_finish
);

    localparam int W  = FIX_POINT_WIDTH;
    localparam int PW = $clog2(DATA_NUM + 1);
    localparam logic [PW-1:0] LAST_PHASE = PW'(DATA_NUM - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SORT = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]           state_q;
    logic [PW-1:0]        phase_q;
    logic                 desc_q;
    logic                 fin_q;
    logic [W-1:0]         max_q;
    logic [W-1:0]         slot_q  [DATA_NUM];
    logic [W-1:0]         slot_nx [DATA_NUM];
    logic [IDX_WIDTH-1:0] idx_q   [DATA_NUM];
    logic [IDX_WIDTH-1:0] idx_nx  [DATA_NUM];
    logic [DATA_NUM-2:0]  swap_en;
    logic                 sort_last;

    function automatic logic greater(input logic [W-1:0] a, input logic [W-1:0] b);
        if (SIGNED != 0)
            return $signed(a) > $signed(b);
        return a > b;
    endfunction

    // swap_en[j] marks the pair (j, j+1); only pairs whose left slot parity matches the phase are live
    always_comb begin
        swap_en = '0;
        for (int j = 0; j < DATA_NUM - 1; j++) begin
            if (1'(j) == phase_q[0]) begin
                if (desc_q)
                    swap_en[j] = greater(slot_q[j+1], slot_q[j]);
                else
                    swap_en[j] = greater(slot_q[j], slot_q[j+1]);
            end
        end
    end

    always_comb begin
        for (int i = 0; i < DATA_NUM; i++) begin
            slot_nx[i] = slot_q[i];
            idx_nx[i]  = idx_q[i];
        end
        for (int j = 0; j < DATA_NUM - 1; j++) begin
            if (swap_en[j]) begin
                slot_nx[j]   = slot_q[j+1];
                slot_nx[j+1] = slot_q[j];
                idx_nx[j]    = idx_q[j+1];
                idx_nx[j+1]  = idx_q[j];
            end
        end
    end

`ifdef SORT_EARLY_EXIT_EN
    // clean_q: the previous phase of this SORT made no swaps (cleared outside SORT so phase 0 never exits)
    logic clean_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            clean_q <= 1'b0;
        else if (state_q == ST_SORT)
            clean_q <= ~|swap_en;
        else
            clean_q <= 1'b0;
    end

    assign sort_last = (phase_q == LAST_PHASE) || (clean_q && ~|swap_en);
`else
    assign sort_last = (phase_q == LAST_PHASE);
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            phase_q <= '0;
            desc_q  <= 1'b0;
            fin_q   <= 1'b0;
            max_q   <= '0;
            for (int i = 0; i < DATA_NUM; i++) begin
                slot_q[i] <= '0;
                idx_q[i]  <= '0;
            end
        end else begin
            fin_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        for (int i = 0; i < DATA_NUM; i++) begin
                            slot_q[i] <= in_data[i*W +: W];
                            idx_q[i]  <= IDX_WIDTH'(i);
                        end
                        desc_q  <= descending;
                        phase_q <= '0;
                        state_q <= ST_SORT;
                    end
                end
                ST_SORT: begin
                    for (int i = 0; i < DATA_NUM; i++) begin
                        slot_q[i] <= slot_nx[i];
                        idx_q[i]  <= idx_nx[i];
                    end
                    phase_q <= phase_q + PW'(1);
                    if (sort_last) begin
                        state_q <= ST_DONE;
                        fin_q   <= 1'b1;
                        max_q   <= desc_q ? slot_nx[0] : slot_nx[DATA_NUM-1];
                    end
                end
                ST_DONE: begin
                    if (out_ready)
                        state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    for (genvar g = 0; g < DATA_NUM; g++) begin : g_out
        assign out_data[g*W +: W]                = slot_q[g];
        assign out_idx[g*IDX_WIDTH +: IDX_WIDTH] = idx_q[g];
    end

    assign in_ready    = (state_q == ST_IDLE);
    assign busy        = (state_q == ST_SORT);
    assign out_valid   = (state_q == ST_DONE);
    assign sort_finish = fin_q;
    assign max_out     = max_q;

endmodule
